// File: rtl/snn_lif_layer_if.sv
// Bus bundle for the snn_lif_layer: timestep handshake, weight write port,
// result outputs and membrane debug readout.
interface snn_lif_layer_if;
    logic       in_valid;
    logic [7:0] in_spikes;
    logic       in_ready;
    logic [7:0] threshold;
    logic [7:0] leak;
    logic       wt_we;
    logic [5:0] wt_addr;
    logic [3:0] wt_data;
    logic       out_valid;
    logic [7:0] out_spikes;
    logic       busy;
    logic [2:0] mem_sel;
    logic [7:0] mem_out;

    // Driver side (the block feeding the layer).
    modport master (
        output in_valid, in_spikes, threshold, leak, wt_we, wt_addr, wt_data, mem_sel,
        input  in_ready, out_valid, out_spikes, busy, mem_out
    );

    // Layer side.
    modport slave (
        input  in_valid, in_spikes, threshold, leak, wt_we, wt_addr, wt_data, mem_sel,
        output in_ready, out_valid, out_spikes, busy, mem_out
    );
endinterface

// File: rtl/snn_lif_layer.sv
// Fully connected layer of 8 leaky integrate-and-fire neurons fed by 8 spike
// inputs. Each accepted input vector runs one timestep, updating one neuron per
// cycle; the resulting spike vector is published with a one-cycle out_valid.
module snn_lif_layer #(
    parameter int unsigned N_IN    = 8,
    parameter int unsigned N_OUT   = 8,
    parameter int unsigned W_WIDTH = 4,
    parameter int unsigned V_WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    snn_lif_layer_if.slave bus
);

    localparam int unsigned J_WIDTH = 3;
    // Wide enough for v + (8 * -8 .. 8 * 7) - leak without overflow.
    localparam int unsigned T_WIDTH = 11;
    localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N_OUT - 1);
    localparam logic signed [T_WIDTH-1:0] V_MAX = T_WIDTH'((1 << V_WIDTH) - 1);

    typedef enum logic [1:0] {StIdle, StUpdate, StDone} state_e;

    state_e                      state_q;
    logic [J_WIDTH-1:0]          j_q;
    logic signed [W_WIDTH-1:0]   w_q [N_IN][N_OUT];
    logic [V_WIDTH-1:0]          v_q [N_OUT];
    logic [N_IN-1:0]             spk_in_q;
    logic [V_WIDTH-1:0]          thr_q;
    logic [V_WIDTH-1:0]          leak_q;
    logic [N_OUT-1:0]            spk_acc_q;
    logic [N_OUT-1:0]            out_spikes_q;
    logic                        out_valid_q;

    logic signed [T_WIDTH-1:0]   syn_sum;
    logic signed [T_WIDTH-1:0]   t_raw;
    logic [V_WIDTH-1:0]          v_clamp;
    logic                        fire;

    // Membrane update for the neuron selected by j_q: integrate, leak, clamp, compare.
    always_comb begin
        syn_sum = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (spk_in_q[i]) begin
                syn_sum = syn_sum + T_WIDTH'(w_q[i][j_q]);
            end
        end
        t_raw = $signed({{(T_WIDTH - V_WIDTH){1'b0}}, v_q[j_q]}) + syn_sum
              - $signed({{(T_WIDTH - V_WIDTH){1'b0}}, leak_q});
        if (t_raw[T_WIDTH-1]) begin
            v_clamp = '0;
        end else if (t_raw > V_MAX) begin
            v_clamp = '1;
        end else begin
            v_clamp = t_raw[V_WIDTH-1:0];
        end
        fire = (v_clamp >= thr_q);
    end

    // Timestep sequencer; DONE lasts two cycles so out_valid is registered and
    // in_ready returns the cycle after the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            j_q          <= '0;
            spk_in_q     <= '0;
            thr_q        <= '0;
            leak_q       <= '0;
            spk_acc_q    <= '0;
            out_spikes_q <= '0;
            out_valid_q  <= 1'b0;
            for (int j = 0; j < int'(N_OUT); j++) begin
                v_q[j] <= '0;
                for (int i = 0; i < int'(N_IN); i++) begin
                    w_q[i][j] <= '0;
                end
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Write lands on the accept edge, so the new weight is
                    // already in place for the first update cycle.
                    if (bus.wt_we) begin
                        w_q[bus.wt_addr[5:3]][bus.wt_addr[2:0]] <= $signed(bus.wt_data);
                    end
                    if (bus.in_valid) begin
                        spk_in_q  <= bus.in_spikes;
                        thr_q     <= bus.threshold;
                        leak_q    <= bus.leak;
                        j_q       <= '0;
                        spk_acc_q <= '0;
                        state_q   <= StUpdate;
                    end
                end
                StUpdate: begin
                    v_q[j_q]       <= fire ? '0 : v_clamp;
                    spk_acc_q[j_q] <= fire;
                    j_q            <= j_q + 1'b1;
                    if (j_q == J_LAST) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (!out_valid_q) begin
                        out_spikes_q <= spk_acc_q;
                        out_valid_q  <= 1'b1;
                    end else begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_spikes = out_spikes_q;
    assign bus.mem_out    = v_q[bus.mem_sel];

endmodule

// File: tb/tb_snn_lif_layer.sv
// Self-checking bench for snn_lif_layer: directed scenarios plus randomized
// timesteps, compared against an arithmetic model of the layer.
module tb_snn_lif_layer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snn_lif_layer_if bus ();

    snn_lif_layer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: weights and membranes as plain integers.
    int mw [8][8];
    int mv [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < 8; j++) begin
            mv[j] = 0;
            for (int i = 0; i < 8; i++) mw[i][j] = 0;
        end
    endtask

    // One timestep of the layer: integrate, leak, clamp to 0..255, fire and reset.
    task automatic model_step(input logic [7:0] s, input int thr, input int lk,
                              output logic [7:0] spk);
        spk = '0;
        for (int j = 0; j < 8; j++) begin
            int t;
            t = mv[j] - lk;
            for (int i = 0; i < 8; i++) if (s[i]) t += mw[i][j];
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            if (t >= thr) begin
                spk[j] = 1'b1;
                mv[j]  = 0;
            end else begin
                mv[j] = t;
            end
        end
    endtask

    task automatic write_w(input int i, input int j, input int val);
        logic [5:0] a;
        logic [3:0] d;
        a = {i[2:0], j[2:0]};
        d = val[3:0];
        bus.wt_we   = 1'b1;
        bus.wt_addr = a;
        bus.wt_data = d;
        @(posedge clk); #1;
        bus.wt_we = 1'b0;
        mw[i][j] = val;
    endtask

    task automatic check_mems(input string tag);
        for (int k = 0; k < 8; k++) begin
            bus.mem_sel = k[2:0];
            @(posedge clk); #1;
            check($sformatf("%s_v%0d", tag, k), {24'd0, bus.mem_out}, mv[k]);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Run one timestep and check latency, result, pulse width and ready return.
    task automatic run_step(input logic [7:0] s, input int thr, input int lk,
                            input string tag, output logic [7:0] exp);
        int cnt;
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.in_spikes = s;
        bus.threshold = thr[7:0];
        bus.leak      = lk[7:0];
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        model_step(s, thr, lk, exp);
        check({tag, "_busy"}, {31'd0, bus.busy}, 1);
        cnt = 1;
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_lat"}, cnt, 10);
        check({tag, "_spk"}, {24'd0, bus.out_spikes}, {24'd0, exp});
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, bus.out_valid}, 0);
        check({tag, "_ready"}, {31'd0, bus.in_ready}, 1);
    endtask

    initial begin
        logic [7:0] exp;
        logic [7:0] got;
        int pulses;

        bus.in_valid  = 1'b0;
        bus.in_spikes = '0;
        bus.threshold = '0;
        bus.leak      = '0;
        bus.wt_we     = 1'b0;
        bus.wt_addr   = '0;
        bus.wt_data   = '0;
        bus.mem_sel   = '0;
        model_clear();

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", {31'd0, bus.in_ready}, 1);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_ovalid", {31'd0, bus.out_valid}, 0);
        check("rst_ospk", {24'd0, bus.out_spikes}, 0);
        check_mems("rst");

        // Integrate then fire.
        write_w(0, 3, 7);
        run_step(8'h01, 10, 0, "if1", exp);
        check("if1_const", {24'd0, bus.out_spikes}, 8'h00);
        check_mems("if1");
        run_step(8'h01, 10, 0, "if2", exp);
        check("if2_const", {24'd0, bus.out_spikes}, 8'h08);
        check_mems("if2");

        // Clamping: neuron 0 floors at 0, neuron 1 saturates and fires at 255.
        for (int i = 0; i < 8; i++) begin
            write_w(i, 0, -8);
            write_w(i, 1, 7);
        end
        for (int k = 0; k < 5; k++) begin
            run_step(8'hFF, 255, 0, $sformatf("clamp%0d", k), exp);
            check($sformatf("clamp%0d_fire1", k), {31'd0, bus.out_spikes[1]}, (k == 4) ? 1 : 0);
        end
        check_mems("clamp");

        // Leak: v[2] = 7 then decays by 3 per step down to the floor.
        write_w(0, 2, 7);
        run_step(8'h01, 200, 0, "lk0", exp);
        for (int k = 0; k < 3; k++) begin
            run_step(8'h00, 200, 3, $sformatf("lk%0d", k + 1), exp);
            bus.mem_sel = 3'd2;
            @(posedge clk); #1;
            check($sformatf("lk%0d_v2", k + 1), {24'd0, bus.mem_out}, (k == 0) ? 4 : (k == 1) ? 1 : 0);
        end

        // Threshold zero fires every neuron.
        run_step(8'h5A, 0, 0, "thr0", exp);
        check("thr0_const", {24'd0, bus.out_spikes}, 8'hFF);

        // Busy protection: in_valid and weight write during UPDATE are ignored.
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.in_spikes = 8'h01;
        bus.threshold = 8'd250;
        bus.leak      = 8'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        model_step(8'h01, 250, 0, exp);
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_spikes = 8'hFF;
        bus.wt_we     = 1'b1;
        bus.wt_addr   = 6'h03;
        bus.wt_data   = 4'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.wt_we    = 1'b0;
        pulses = 0;
        got    = '0;
        for (int c = 0; c < 25; c++) begin
            if (bus.out_valid) begin
                pulses++;
                got = bus.out_spikes;
            end
            @(posedge clk); #1;
        end
        check("busy_pulses", pulses, 1);
        check("busy_spk", {24'd0, got}, {24'd0, exp});
        run_step(8'h01, 250, 0, "busy_w", exp);
        check_mems("busy_w");

        // Reset four cycles after accept abandons the timestep.
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.in_spikes = 8'hFF;
        bus.threshold = 8'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        check("mrst_ready", {31'd0, bus.in_ready}, 1);
        check("mrst_busy", {31'd0, bus.busy}, 0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.out_valid) pulses++;
            @(posedge clk); #1;
        end
        check("mrst_pulses", pulses, 0);
        check("mrst_ospk", {24'd0, bus.out_spikes}, 0);
        check_mems("mrst");

        // Randomized weights and timesteps.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                write_w(i, j, int'($urandom_range(0, 15)) - 8);
            end
        end
        for (int k = 0; k < 20; k++) begin
            logic [7:0] s;
            s = 8'($urandom);
            run_step(s, int'($urandom_range(20, 200)), int'($urandom_range(0, 10)),
                     $sformatf("rnd%0d", k), exp);
            if (k % 5 == 4) check_mems($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
